// File: rtl/can_pkg.sv
// Shared CAN definitions: field widths, scheduler state encoding, frame payload struct
// and a DLC clamp helper. Imported by can_tx_scheduler and can_id_min_sel.
package can_pkg;

   localparam int unsigned CAN_ID_W    = 11;
   localparam int unsigned CAN_DLC_W   = 4;
   localparam int unsigned CAN_DLC_MAX = 8;
   localparam int unsigned CAN_DATA_W  = 64;
   localparam int unsigned CAN_CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEL   = 2'd1,
      ST_OFFER = 2'd2,
      ST_WAIT  = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic [CAN_ID_W-1:0]   id;
      logic [CAN_DLC_W-1:0]  len;
      logic [CAN_DATA_W-1:0] data;
   } can_frame_t;

   // DLC codes 9..15 carry 8 data bytes on classic CAN
   function automatic logic [CAN_DLC_W-1:0] clamp_dlc(input logic [CAN_DLC_W-1:0] dlc);
      return (dlc > CAN_DLC_W'(CAN_DLC_MAX)) ? CAN_DLC_W'(CAN_DLC_MAX) : dlc;
   endfunction

endpackage

// File: rtl/can_id_min_sel.sv
// Combinational arbiter: finds the pending entry with the lowest ID; ties go to the
// lowest index, matching CAN bus priority.
// Ports:
//   pending_i  N flags, entry eligible for selection
//   id_i       N IDs
//   found_o    at least one entry pending
//   idx_o      index of the winning entry (0 when none)
module can_id_min_sel
   import can_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]               pending_i,
   input  logic [N-1:0][CAN_ID_W-1:0] id_i,
   output logic                       found_o,
   output logic [IDX_W-1:0]           idx_o
);

   logic                found;
   logic [IDX_W-1:0]    idx;
   logic [CAN_ID_W-1:0] best_id;

   // Strict '<' keeps the earlier (lower) index on equal IDs
   always_comb begin
      found   = 1'b0;
      idx     = '0;
      best_id = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (pending_i[i] && (!found || (id_i[i] < best_id))) begin
            found   = 1'b1;
            idx     = IDX_W'(i);
            best_id = id_i[i];
         end
      end
   end

   assign found_o = found;
   assign idx_o   = idx;

endmodule

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: NMB mailboxes, lowest-ID arbitration before every attempt,
// one frame at a time offered to the packet engine, bounded retries on lost/errored frames.
// Optional feature macro: CAN_TX_ABORT_EN adds the mb_abort input (per-mailbox abort).
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   mb_load/id/len/data  per-mailbox load strobe and packed frame fields
//   mb_abort             (CAN_TX_ABORT_EN only) per-mailbox abort request
//   mb_busy/done/fail    mailbox occupied, success pulse, give-up pulse
//   pkt_valid/ready      frame handoff to packet engine, with pkt_id/len/data
//   pkt_end/pkt_ok       attempt finished, qualified by success
module can_tx_scheduler
   import can_pkg::*;
#(
   parameter int unsigned NMB       = 4,
   parameter int unsigned RETRY_MAX = 8
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NMB-1:0]            mb_load,
   input  logic [NMB*CAN_ID_W-1:0]   mb_id,
   input  logic [NMB*CAN_DLC_W-1:0]  mb_len,
   input  logic [NMB*CAN_DATA_W-1:0] mb_data,
`ifdef CAN_TX_ABORT_EN
   input  logic [NMB-1:0]            mb_abort,
`endif
   output logic [NMB-1:0]            mb_busy,
   output logic [NMB-1:0]            mb_done,
   output logic [NMB-1:0]            mb_fail,
   output logic                      pkt_valid,
   input  logic                      pkt_ready,
   output logic [CAN_ID_W-1:0]       pkt_id,
   output logic [CAN_DLC_W-1:0]      pkt_len,
   output logic [CAN_DATA_W-1:0]     pkt_data,
   input  logic                      pkt_end,
   input  logic                      pkt_ok
);

   localparam int unsigned IDX_W = (NMB > 1) ? $clog2(NMB) : 1;

   sched_state_e                       state_q;
   can_frame_t [NMB-1:0]               mb_q;
   logic [NMB-1:0]                     busy_q;
   logic [NMB-1:0]                     done_q;
   logic [NMB-1:0]                     fail_q;
   logic [NMB-1:0][CAN_CNT_W-1:0]      cnt_q;
   logic [IDX_W-1:0]                   win_q;
   logic                               abort_pend_q;
   logic                               pkt_valid_q;
   can_frame_t                         pkt_q;

   logic [NMB-1:0]                     abort_c;
   logic [NMB-1:0]                     pending_c;
   logic                               in_flight_c;
   logic [NMB-1:0][CAN_ID_W-1:0]       id_vec_c;
   logic                               sel_found_c;
   logic [IDX_W-1:0]                   sel_idx_c;

`ifdef CAN_TX_ABORT_EN
   assign abort_c = mb_abort;
`else
   assign abort_c = '0;
`endif

   // Mailboxes being aborted this cycle are not eligible for arbitration
   assign pending_c   = busy_q & ~abort_c;
   assign in_flight_c = (state_q == ST_OFFER) || (state_q == ST_WAIT);

   always_comb begin
      id_vec_c = '0;
      for (int i = 0; i < int'(NMB); i++) begin
         id_vec_c[i] = mb_q[i].id;
      end
   end

   can_id_min_sel #(
      .N     (NMB),
      .IDX_W (IDX_W)
   ) u_sel (
      .pending_i (pending_c),
      .id_i      (id_vec_c),
      .found_o   (sel_found_c),
      .idx_o     (sel_idx_c)
   );

   // Mailbox storage plus scheduler FSM; release of the in-flight mailbox is done by the
   // FSM, and its assignments take precedence over the per-mailbox loop above them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         mb_q         <= '0;
         busy_q       <= '0;
         done_q       <= '0;
         fail_q       <= '0;
         cnt_q        <= '0;
         win_q        <= '0;
         abort_pend_q <= 1'b0;
         pkt_valid_q  <= 1'b0;
         pkt_q        <= '0;
      end else begin
         done_q <= '0;
         fail_q <= '0;

         for (int i = 0; i < int'(NMB); i++) begin
            if (mb_load[i] && !busy_q[i]) begin
               mb_q[i].id   <= mb_id[i*CAN_ID_W +: CAN_ID_W];
               mb_q[i].len  <= clamp_dlc(mb_len[i*CAN_DLC_W +: CAN_DLC_W]);
               mb_q[i].data <= mb_data[i*CAN_DATA_W +: CAN_DATA_W];
               busy_q[i]    <= 1'b1;
               cnt_q[i]     <= '0;
            end else if (busy_q[i] && abort_c[i] && !(in_flight_c && (win_q == IDX_W'(i)))) begin
               busy_q[i] <= 1'b0;
               fail_q[i] <= 1'b1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (|pending_c) state_q <= ST_SEL;
            end
            ST_SEL: begin
               if (sel_found_c) begin
                  win_q       <= sel_idx_c;
                  pkt_q       <= mb_q[sel_idx_c];
                  pkt_valid_q <= 1'b1;
                  state_q     <= ST_OFFER;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_OFFER: begin
               // A handoff on the same edge as an abort wins; the abort then applies in WAIT
               if (pkt_ready) begin
                  pkt_valid_q  <= 1'b0;
                  abort_pend_q <= abort_c[win_q];
                  state_q      <= ST_WAIT;
               end else if (abort_c[win_q]) begin
                  pkt_valid_q    <= 1'b0;
                  busy_q[win_q]  <= 1'b0;
                  fail_q[win_q]  <= 1'b1;
                  state_q        <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (pkt_end) begin
                  abort_pend_q <= 1'b0;
                  state_q      <= ST_IDLE;
                  if (pkt_ok) begin
                     done_q[win_q] <= 1'b1;
                     busy_q[win_q] <= 1'b0;
                  end else if (!abort_pend_q && !abort_c[win_q] &&
                               (cnt_q[win_q] < CAN_CNT_W'(RETRY_MAX))) begin
                     cnt_q[win_q] <= cnt_q[win_q] + CAN_CNT_W'(1);
                  end else begin
                     fail_q[win_q] <= 1'b1;
                     busy_q[win_q] <= 1'b0;
                  end
               end else if (abort_c[win_q]) begin
                  abort_pend_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mb_busy   = busy_q;
   assign mb_done   = done_q;
   assign mb_fail   = fail_q;
   assign pkt_valid = pkt_valid_q;
   assign pkt_id    = pkt_q.id;
   assign pkt_len   = pkt_q.len;
   assign pkt_data  = pkt_q.data;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Testbench for can_tx_scheduler: directed scenarios with literal expectations, then a
// randomized run; a transaction-level mailbox/arbitration model is compared every cycle.
module tb_can_tx_scheduler;

   localparam int NMB = 4;
   localparam int RM  = 2;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NMB-1:0]    mb_load;
   logic [NMB*11-1:0] mb_id;
   logic [NMB*4-1:0]  mb_len;
   logic [NMB*64-1:0] mb_data;
   logic [NMB-1:0]    mb_abort;
   logic [NMB-1:0]    mb_busy, mb_done, mb_fail;
   logic              pkt_valid, pkt_ready, pkt_end, pkt_ok;
   logic [10:0]       pkt_id;
   logic [3:0]        pkt_len;
   logic [63:0]       pkt_data;

   int total = 0;
   int bad   = 0;

   can_tx_scheduler #(.NMB(NMB), .RETRY_MAX(RM)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .mb_load   (mb_load),
      .mb_id     (mb_id),
      .mb_len    (mb_len),
      .mb_data   (mb_data),
`ifdef CAN_TX_ABORT_EN
      .mb_abort  (mb_abort),
`endif
      .mb_busy   (mb_busy),
      .mb_done   (mb_done),
      .mb_fail   (mb_fail),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .pkt_id    (pkt_id),
      .pkt_len   (pkt_len),
      .pkt_data  (pkt_data),
      .pkt_end   (pkt_end),
      .pkt_ok    (pkt_ok)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_busy [NMB];
   logic [10:0] m_id   [NMB];
   logic [3:0]  m_len  [NMB];
   logic [63:0] m_data [NMB];
   int          m_cnt  [NMB];
   bit          m_off, m_wait, m_choose;
   int          m_cur;
   logic [NMB-1:0] m_done, m_fail;

   task automatic model_reset();
      for (int i = 0; i < NMB; i++) begin
         m_busy[i] = 0; m_id[i] = '0; m_len[i] = '0; m_data[i] = '0; m_cnt[i] = 0;
      end
      m_off = 0; m_wait = 0; m_choose = 0; m_cur = 0;
      m_done = '0; m_fail = '0;
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic model_step();
      bit nb [NMB];
      bit any;
      int best;
      logic [3:0] l;
      nb = m_busy;
      m_done = '0;
      m_fail = '0;
      any = 0;
      for (int i = 0; i < NMB; i++) any |= m_busy[i];
      for (int i = 0; i < NMB; i++) begin
         if (mb_load[i] && !m_busy[i]) begin
            l         = mb_len[i*4 +: 4];
            m_id[i]   = mb_id[i*11 +: 11];
            m_len[i]  = (l > 4'd8) ? 4'd8 : l;
            m_data[i] = mb_data[i*64 +: 64];
            m_cnt[i]  = 0;
            nb[i]     = 1;
         end
      end
      if (m_wait) begin
         if (pkt_end) begin
            m_wait = 0;
            if (pkt_ok) begin
               m_done[m_cur] = 1'b1; nb[m_cur] = 0;
            end else if (m_cnt[m_cur] < RM) begin
               m_cnt[m_cur]++;
            end else begin
               m_fail[m_cur] = 1'b1; nb[m_cur] = 0;
            end
         end
      end else if (m_off) begin
         if (pkt_ready) begin m_off = 0; m_wait = 1; end
      end else if (m_choose) begin
         m_choose = 0;
         best = -1;
         for (int i = 0; i < NMB; i++)
            if (m_busy[i] && (best < 0 || m_id[i] < m_id[best])) best = i;
         if (best >= 0) begin m_off = 1; m_cur = best; end
      end else if (any) begin
         m_choose = 1;
      end
      m_busy = nb;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [NMB-1:0] eb;
      for (int i = 0; i < NMB; i++) eb[i] = m_busy[i];
      chk("mb_busy",   64'(mb_busy),   64'(eb));
      chk("mb_done",   64'(mb_done),   64'(m_done));
      chk("mb_fail",   64'(mb_fail),   64'(m_fail));
      chk("pkt_valid", 64'(pkt_valid), 64'(m_off));
      if (m_off) begin
         chk("pkt_id",   64'(pkt_id),   64'(m_id[m_cur]));
         chk("pkt_len",  64'(pkt_len),  64'(m_len[m_cur]));
         chk("pkt_data", pkt_data,      m_data[m_cur]);
      end
   endtask

   // One clock: model advance, edge, strobes cleared and outputs compared at the negedge
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      mb_load = '0;
      pkt_end = 1'b0;
      check_all();
   endtask

   task automatic load(input int i, input logic [10:0] id, input logic [3:0] len, input logic [63:0] d);
      mb_load[i]         = 1'b1;
      mb_id[i*11 +: 11]  = id;
      mb_len[i*4 +: 4]   = len;
      mb_data[i*64 +: 64] = d;
   endtask

   // Wait (bounded) for an offer, record its ID, then hand it off
   task automatic handoff(output logic [10:0] id);
      int n = 0;
      while (!pkt_valid && n < 20) begin cycle(); n++; end
      chk("offer_seen", 64'(pkt_valid), 64'(1));
      id = pkt_id;
      pkt_ready = 1'b1;
      cycle();
      pkt_ready = 1'b0;
   endtask

   task automatic serve(input bit ok, output logic [10:0] id,
                        output logic [NMB-1:0] dv, output logic [NMB-1:0] fv);
      handoff(id);
      repeat (2) cycle();
      pkt_end = 1'b1;
      pkt_ok  = ok;
      cycle();
      dv = mb_done;
      fv = mb_fail;
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [10:0]    id;
      logic [NMB-1:0] dv, fv;
      logic           seen;

      rstn = 1'b0; mb_load = '0; mb_id = '0; mb_len = '0; mb_data = '0; mb_abort = '0;
      pkt_ready = 1'b0; pkt_end = 1'b0; pkt_ok = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      chk("rst_pkt_id",   64'(pkt_id),   64'(0));
      chk("rst_pkt_len",  64'(pkt_len),  64'(0));
      chk("rst_pkt_data", pkt_data,      64'(0));
      rstn = 1'b1;
      cycle();

      // 1: single frame, latency and fields
      load(2, 11'h123, 4'd3, 64'hAABBCC1122334455);
      cycle();
      chk("t1_busy_after_load", 64'(mb_busy), 64'(4'b0100));
      chk("t1_valid_t0", 64'(pkt_valid), 64'(0));
      cycle();
      chk("t1_valid_t1", 64'(pkt_valid), 64'(0));
      cycle();
      chk("t1_valid_t2", 64'(pkt_valid), 64'(1));
      chk("t1_id",   64'(pkt_id),  64'(11'h123));
      chk("t1_len",  64'(pkt_len), 64'(3));
      chk("t1_data", pkt_data,     64'hAABBCC1122334455);
      pkt_ready = 1'b1; cycle(); pkt_ready = 1'b0;
      chk("t1_valid_dropped", 64'(pkt_valid), 64'(0));
      pkt_end = 1'b1; pkt_ok = 1'b1; cycle();
      chk("t1_done", 64'(mb_done), 64'(4'b0100));
      chk("t1_busy_released", 64'(mb_busy), 64'(0));
      cycle();
      chk("t1_done_one_cycle", 64'(mb_done), 64'(0));

      // 2: ID priority and index tie-break
      load(0, 11'h400, 4'd8, 64'h0000_0000_0000_0400);
      load(3, 11'h010, 4'd2, 64'h0000_0000_0000_0010);
      cycle();
      serve(1'b1, id, dv, fv);
      chk("t2_first_id", 64'(id), 64'(11'h010));
      chk("t2_first_done", 64'(dv), 64'(4'b1000));
      serve(1'b1, id, dv, fv);
      chk("t2_second_id", 64'(id), 64'(11'h400));
      chk("t2_second_done", 64'(dv), 64'(4'b0001));
      load(1, 11'h055, 4'd1, 64'h1111);
      load(2, 11'h055, 4'd1, 64'h2222);
      cycle();
      serve(1'b1, id, dv, fv);
      chk("t2_tie_first", 64'(dv), 64'(4'b0010));
      serve(1'b1, id, dv, fv);
      chk("t2_tie_second", 64'(dv), 64'(4'b0100));

      // 3: retries exhausted after RM+1 attempts
      load(1, 11'h222, 4'd4, 64'h3333);
      cycle();
      serve(1'b0, id, dv, fv);
      chk("t3_try1_fail", 64'(fv), 64'(0));
      chk("t3_try1_busy", 64'(mb_busy), 64'(4'b0010));
      serve(1'b0, id, dv, fv);
      chk("t3_try2_fail", 64'(fv), 64'(0));
      serve(1'b0, id, dv, fv);
      chk("t3_try3_fail", 64'(fv), 64'(4'b0010));
      chk("t3_released", 64'(mb_busy), 64'(0));
      seen = 1'b0;
      repeat (6) begin cycle(); seen |= pkt_valid; end
      chk("t3_no_fourth_attempt", 64'(seen), 64'(0));

      // 4: retry pre-empted by a higher-priority frame loaded during WAIT
      load(0, 11'h300, 4'd5, 64'h4444);
      cycle();
      handoff(id);
      chk("t4_first", 64'(id), 64'(11'h300));
      load(1, 11'h100, 4'd6, 64'h5555);
      cycle();
      pkt_end = 1'b1; pkt_ok = 1'b0; cycle();
      chk("t4_lost_still_busy", 64'(mb_busy), 64'(4'b0011));
      serve(1'b1, id, dv, fv);
      chk("t4_preempt", 64'(id), 64'(11'h100));
      serve(1'b1, id, dv, fv);
      chk("t4_retry", 64'(id), 64'(11'h300));

      // 5: DLC clamp, load into a busy mailbox ignored, offer held stable
      load(0, 11'h7FF, 4'd12, 64'hDEADBEEFCAFEF00D);
      cycle();
      load(0, 11'h001, 4'd2, 64'h1);
      cycle();
      repeat (3) cycle();
      chk("t5_valid", 64'(pkt_valid), 64'(1));
      chk("t5_id",    64'(pkt_id),    64'(11'h7FF));
      chk("t5_len",   64'(pkt_len),   64'(8));
      chk("t5_data",  pkt_data,       64'hDEADBEEFCAFEF00D);
      serve(1'b1, id, dv, fv);
      chk("t5_done", 64'(dv), 64'(4'b0001));

      // 6: asynchronous reset during WAIT
      load(3, 11'h050, 4'd7, 64'h6666);
      cycle();
      handoff(id);
      cycle();
      rstn = 1'b0;
      #1;
      chk("t6_busy",  64'(mb_busy),   64'(0));
      chk("t6_valid", 64'(pkt_valid), 64'(0));
      chk("t6_id",    64'(pkt_id),    64'(0));
      chk("t6_data",  pkt_data,       64'(0));
      model_reset();
      @(negedge clk);
      check_all();
      rstn = 1'b1;
      cycle();

      // Randomized traffic; narrow ID range first to exercise ties
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NMB; i++)
            if ($urandom_range(0, 9) == 0)
               load(i, 11'($urandom_range(0, (c < 1500) ? 15 : 2047)),
                    4'($urandom_range(0, 15)), {$urandom, $urandom});
         pkt_ready = ($urandom_range(0, 1) == 1);
         pkt_end   = ($urandom_range(0, 3) == 0);
         pkt_ok    = ($urandom_range(0, 2) != 0);
         cycle();
      end
      pkt_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
